fir_decim_q10: RTL and testbench

- Streaming decimating FIR filter for the FM receive chain, sitting between the sample source and the demodulator.
- Coefficients and samples are Q10 signed fixed point (32-bit, 10 fractional bits).
- Uses one Q10 multiply per cycle with the team's fixed-point product rule, accumulated into a 32-bit sum.
- Emits one filtered sample per DECIM accepted input samples over a valid/ready stream.

---
 rtl/fir_decim_q10.sv | 177 +++++++++++++++++
 tb/tb_fir_decim_q10.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_q10.sv
// fir_decim_q10: streaming decimating FIR filter for the FM receive chain.
// Samples and coefficients are Q10 signed (32-bit, 10 fractional bits).
// The datapath has one multiplier. After DECIM input samples have been
// accepted, the filter runs TAPS multiply-accumulate cycles over the circular
// sample buffer, newest sample first. It then presents the sum on a
// valid/ready output port and holds it there until downstream takes it.
module fir_decim_q10 #(
    parameter int TAPS  = 8,
    parameter int DECIM = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [31:0]             coef_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data
);

    localparam int AW = $clog2(TAPS);
    localparam int CW = $clog2(DECIM + 1);

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_MAC    = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [AW-1:0] k_q, k_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   samp_q [TAPS];
    logic [31:0]   samp_d [TAPS];
    logic [31:0]   coef_q [TAPS];
    logic [31:0]   coef_d [TAPS];

    logic [AW:0]          rd_sum;
    logic [AW-1:0]        rd_idx;
    logic signed [63:0]   prod;
    logic [31:0]          term;
    logic [CW-1:0]        dcnt_inc;
    logic                 prod_unused;

    // The handshake outputs are decoded directly from the state, so reset
    // drives them to their idle values with no delay.
    assign in_ready  = (state_q == ST_ACCEPT);
    assign out_valid = (state_q == ST_OUTPUT);
    assign out_data  = acc_q;

    // Read index (wptr-1-k) mod TAPS. Adding TAPS first keeps the value
    // non-negative, and a single conditional subtract then wraps it. This
    // works for TAPS values that are not a power of two. The product is the
    // full 64-bit signed product. Bits [41:10] are kept, which gives an
    // arithmetic shift right by 10 (flooring) truncated to 32 bits.
    always_comb begin
        rd_sum = {1'b0, wptr_q} + (AW + 1)'(TAPS) - (AW + 1)'(1) - {1'b0, k_q};
        if (rd_sum >= (AW + 1)'(TAPS)) begin
            rd_sum = rd_sum - (AW + 1)'(TAPS);
        end
        rd_idx = rd_sum[AW-1:0];
        prod   = 64'($signed(coef_q[k_q])) * 64'($signed(samp_q[rd_idx]));
        term   = prod[41:10];
    end

    // The discarded product bits are folded together and left unused on purpose.
    assign prod_unused = ^{prod[63:42], prod[9:0]};

    // Next-state logic for the ACCEPT -> MAC -> OUTPUT sequence. Coefficient
    // writes are honoured only while accepting. A coefficient write and an
    // input transfer in the same cycle both take effect.
    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        dcnt_d   = dcnt_q;
        k_d      = k_q;
        acc_d    = acc_q;
        samp_d   = samp_q;
        coef_d   = coef_q;
        dcnt_inc = dcnt_q + CW'(1);
        case (state_q)
            ST_ACCEPT: begin
                if (coef_we && (int'(coef_addr) < TAPS)) begin
                    coef_d[coef_addr] = coef_data;
                end
                if (in_valid) begin
                    samp_d[wptr_q] = in_data;
                    if (wptr_q == AW'(TAPS - 1)) begin
                        wptr_d = '0;
                    end else begin
                        wptr_d = wptr_q + AW'(1);
                    end
                    if (dcnt_inc == CW'(DECIM)) begin
                        dcnt_d  = '0;
                        acc_d   = '0;
                        k_d     = '0;
                        state_d = ST_MAC;
                    end else begin
                        dcnt_d = dcnt_inc;
                    end
                end
            end
            ST_MAC: begin
                acc_d = acc_q + term;
                if (k_q == AW'(TAPS - 1)) begin
                    k_d     = '0;
                    state_d = ST_OUTPUT;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // Control registers: state, write pointer, decimation count, tap index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ACCEPT;
            wptr_q  <= '0;
            dcnt_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            dcnt_q  <= dcnt_d;
            k_q     <= k_d;
        end
    end

    // Accumulator, which also holds the output sample while it is presented.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Circular sample buffer. Reset clears it, so taps that reach back before
    // the first sample read as zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                samp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                samp_q[i] <= samp_d[i];
            end
        end
    end

    // Coefficient bank.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= coef_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_decim_q10.sv
// Testbench for fir_decim_q10. Instance a has TAPS=4 and DECIM=1 and is used
// for the impulse, truncation, backpressure, dropped-write and reset cases.
// Instance b has TAPS=8 and DECIM=4 and is used for constant-input
// decimation and for the in_ready low time of each group.
module tb_fir_decim_q10;

    logic        clock;
    logic        reset_n;

    logic        a_coef_we;
    logic [1:0]  a_coef_addr;
    logic [31:0] a_coef_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_in_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [31:0] a_out_data;

    logic        b_coef_we;
    logic [2:0]  b_coef_addr;
    logic [31:0] b_coef_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_data;

    int n_compared;
    int n_mismatched;

    // One vector record. kind 0 writes a coefficient (addr, val). kind 1 sends
    // the sample val and expects exp. kind 2 sends the sample val under
    // backpressure and expects exp. mac_wr also drives a dropped h[0]=5000
    // write while the filter is in MAC.
    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] val;
        logic [31:0] exp;
        bit          mac_wr;
        string       name;
    } vec_t;

    vec_t tbl[$];

    fir_decim_q10 #(.TAPS(4), .DECIM(1)) dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .coef_we   (a_coef_we),
        .coef_addr (a_coef_addr),
        .coef_data (a_coef_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data)
    );

    fir_decim_q10 #(.TAPS(8), .DECIM(4)) dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .coef_we   (b_coef_we),
        .coef_addr (b_coef_addr),
        .coef_data (b_coef_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input int kind, input int addr, input logic [31:0] val,
                       input logic [31:0] exp, input bit mac_wr, input string name);
        vec_t v;
        v.kind = kind; v.addr = addr; v.val = val; v.exp = exp; v.mac_wr = mac_wr; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic writeCoefA(input int addr, input logic [31:0] val);
        @(negedge clock);
        a_coef_we   = 1'b1;
        a_coef_addr = 2'(addr);
        a_coef_data = val;
        @(negedge clock);
        a_coef_we   = 1'b0;
    endtask

    // Sends one sample to instance a (so one output per sample) and checks the
    // latency, the value, and that out_valid lasts a single cycle.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] exp_y,
                                 input bit mac_wr, input string name);
        int lat;
        @(negedge clock);
        checkOutput({name, "_in_ready"}, 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1;
        a_in_data  = x;
        @(negedge clock);
        a_in_valid = 1'b0;
        a_in_data  = '0;
        if (mac_wr) begin
            a_coef_we   = 1'b1;
            a_coef_addr = 2'd0;
            a_coef_data = 32'd5000;
        end
        lat = 0;
        while (!a_out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        a_coef_we = 1'b0;
        checkOutput({name, "_latency"}, 32'(lat), 32'd4);
        checkOutput({name, "_data"}, a_out_data, exp_y);
        @(negedge clock);
        checkOutput({name, "_valid_drop"}, 32'(a_out_valid), 32'd0);
        checkOutput({name, "_ready_back"}, 32'(a_in_ready), 32'd1);
    endtask

    // Holds the output under backpressure while offering a sample that must
    // not be accepted.
    task automatic backpressureSeq(input logic [31:0] x, input logic [31:0] exp_y);
        int lat;
        a_out_ready = 1'b0;
        @(negedge clock);
        a_in_valid = 1'b1;
        a_in_data  = x;
        @(negedge clock);
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        checkOutput("bp_latency", 32'(lat), 32'd4);
        checkOutput("bp_data", a_out_data, exp_y);
        a_in_valid = 1'b1;
        a_in_data  = 32'd777;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(a_out_valid), 32'd1);
            checkOutput($sformatf("bp_hold_data_%0d", i), a_out_data, exp_y);
            checkOutput($sformatf("bp_hold_in_ready_%0d", i), 32'(a_in_ready), 32'd0);
        end
        a_out_ready = 1'b1;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        @(negedge clock);
        checkOutput("bp_release_valid", 32'(a_out_valid), 32'd0);
        checkOutput("bp_release_in_ready", 32'(a_in_ready), 32'd1);
    endtask

    // Main sequence.
    initial begin
        int low_cnt, val_cnt;
        bit seen_low;
        n_compared   = 0;
        n_mismatched = 0;
        reset_n = 1'b0;
        a_coef_we = 0; a_coef_addr = 0; a_coef_data = 0;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 1'b1;
        b_coef_we = 0; b_coef_addr = 0; b_coef_data = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 1'b1;

        // Vector table covering impulse response, truncation, backpressure,
        // buffer flush and the dropped coefficient write.
        add(0, 0, 32'd1024, 0, 0, "h0");
        add(0, 1, 32'd2048, 0, 0, "h1");
        add(0, 2, 32'd0,    0, 0, "h2");
        add(0, 3, 32'(-1024), 0, 0, "h3");
        add(1, 0, 32'd1024, 32'd1024,   0, "imp0");
        add(1, 0, 32'd0,    32'd2048,   0, "imp1");
        add(1, 0, 32'd0,    32'd0,      0, "imp2");
        add(1, 0, 32'd0,    32'(-1024), 0, "imp3");
        add(1, 0, 32'd0,    32'd0,      0, "imp4");
        add(0, 0, 32'd1, 0, 0, "t_h0");
        add(0, 1, 32'd0, 0, 0, "t_h1");
        add(0, 3, 32'd0, 0, 0, "t_h3");
        add(1, 0, 32'd1,          32'd0,          0, "trunc_pos");
        add(1, 0, 32'hFFFFFFFF,   32'hFFFFFFFF,   0, "trunc_neg");
        add(0, 0, 32'd2048, 0, 0, "w_h0");
        add(1, 0, 32'h7FFFFFFF,   32'hFFFFFFFE,   0, "wrap");
        add(2, 0, 32'd3, 32'd6, 0, "bp");
        add(0, 1, 32'd2048, 0, 0, "bp_h1");
        add(1, 0, 32'd5, 32'd16, 0, "bp_noaccept");
        add(1, 0, 32'd0, 32'd10, 0, "flush0");
        add(1, 0, 32'd0, 32'd0,  0, "flush1");
        add(1, 0, 32'd0, 32'd0,  0, "flush2");
        add(1, 0, 32'd0, 32'd0,  0, "flush3");
        add(0, 0, 32'd1024, 0, 0, "r_h0");
        add(0, 1, 32'd2048, 0, 0, "r_h1");
        add(0, 2, 32'd0,    0, 0, "r_h2");
        add(0, 3, 32'(-1024), 0, 0, "r_h3");
        add(1, 0, 32'd1024, 32'd1024,   1, "mw_imp0");
        add(1, 0, 32'd0,    32'd2048,   1, "mw_imp1");
        add(1, 0, 32'd0,    32'd0,      1, "mw_imp2");
        add(1, 0, 32'd0,    32'(-1024), 1, "mw_imp3");
        add(1, 0, 32'd0,    32'd0,      0, "mw_imp4");
        add(1, 0, 32'd1024, 32'd1024,   0, "h0_kept0");
        add(1, 0, 32'd0,    32'd2048,   0, "h0_kept1");
        add(1, 0, 32'd0,    32'd0,      0, "h0_kept2");
        add(1, 0, 32'd0,    32'(-1024), 0, "h0_kept3");
        add(1, 0, 32'd0,    32'd0,      0, "h0_kept4");
        add(0, 0, 32'd5000, 0, 0, "acc_h0");
        add(1, 0, 32'd1024, 32'd5000,   0, "accept_write");

        repeat (3) @(negedge clock);
        checkOutput("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        checkOutput("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_a_out_data",  a_out_data,       32'd0);
        checkOutput("rst_b_in_ready",  32'(b_in_ready),  32'd1);
        checkOutput("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        reset_n = 1'b1;

        // Instance b: every h = 0.125 and a constant input of 1.0.
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            b_coef_we = 1'b1; b_coef_addr = 3'(k); b_coef_data = 32'd128;
        end
        @(negedge clock);
        b_coef_we  = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = 32'd1024;
        for (int g = 0; g < 3; g++) begin
            low_cnt = 0; val_cnt = 0; seen_low = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clock);
                if (!b_in_ready) begin
                    low_cnt++;
                    seen_low = 1;
                end
                if (b_out_valid) begin
                    val_cnt++;
                    checkOutput($sformatf("dec_data_g%0d", g), b_out_data,
                                (g == 0) ? 32'd512 : 32'd1024);
                end
                if (seen_low && b_in_ready) break;
            end
            checkOutput($sformatf("dec_ready_low_g%0d", g), 32'(low_cnt), 32'd9);
            checkOutput($sformatf("dec_valid_cycles_g%0d", g), 32'(val_cnt), 32'd1);
        end
        b_in_valid = 1'b0;

        // Instance a: apply the vector table.
        foreach (tbl[i]) begin
            case (tbl[i].kind)
                0: writeCoefA(tbl[i].addr, tbl[i].val);
                1: applyStimulus(tbl[i].val, tbl[i].exp, tbl[i].mac_wr, tbl[i].name);
                default: backpressureSeq(tbl[i].val, tbl[i].exp);
            endcase
        end

        // Asynchronous reset in the middle of a MAC.
        @(negedge clock);
        a_in_valid = 1'b1;
        a_in_data  = 32'd1024;
        @(negedge clock);
        a_in_valid = 1'b0;
        @(negedge clock);
        checkOutput("pre_rst_in_ready", 32'(a_in_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_in_ready",  32'(a_in_ready),  32'd1);
        checkOutput("async_rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("async_rst_out_data",  a_out_data,       32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(32'd1024, 32'd0, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
